// File: rtl/cbus_arbiter.sv
// rtl/cbus_arbiter.sv - round-robin arbiter sharing one cbus memory port between several masters
//
// Purpose: grants the downstream cbus to one requester for a complete burst,
// from the grant cycle until the response beat carrying ready && last. The
// search for the next owner starts one past the previous owner, so grants
// rotate fairly. Only the owner's request is forwarded and only the owner
// sees the memory response; everything else reads as zero.
//
// Ports:
//   clk     in   single clock, rising edge
//   reset   in   asynchronous active-high reset
//   ireqs   in   NUM_INPUTS x cbus_req_t, requests from the masters
//   oresps  out  NUM_INPUTS x cbus_resp_t, responses to the masters
//   oreq    out  cbus_req_t, request to the memory side
//   iresp   in   cbus_resp_t, response from the memory side

package cbus_pkg;
  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [63:0] addr;
    logic [7:0]  len;      // beats minus one
    logic [1:0]  burst;
    logic [63:0] data;
    logic [7:0]  strobe;
  } cbus_req_t;            // 151 bits

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;           // 66 bits

  localparam logic [7:0] MLEN1  = 8'd0;
  localparam logic [7:0] MLEN2  = 8'd1;
  localparam logic [7:0] MLEN4  = 8'd3;
  localparam logic [7:0] MLEN8  = 8'd7;
  localparam logic [7:0] MLEN16 = 8'd15;
endpackage

module cbus_arbiter
  import cbus_pkg::*;
#(
  parameter int NUM_INPUTS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  cbus_req_t  ireqs  [NUM_INPUTS],
  output cbus_resp_t oresps [NUM_INPUTS],
  output cbus_req_t  oreq,
  input  cbus_resp_t iresp
);

  localparam int IW = $clog2(NUM_INPUTS);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] last_grant_q, last_grant_d;
  logic          found;
  logic [IW-1:0] cand;

  // Resetting last_grant to the top index makes input 0 the first choice.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      last_grant_q <= IW'(NUM_INPUTS - 1);
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    found        = 1'b0;
    cand         = '0;
    case (state_q)
      IDLE: begin
        // Scan last_grant+1 .. last_grant+NUM_INPUTS; the final candidate is
        // the previous owner itself, so a lone requester can be re-granted.
        for (int k = 1; k <= NUM_INPUTS; k++) begin
          cand = IW'((int'(last_grant_q) + k) % NUM_INPUTS);
          if (!found && ireqs[cand].valid) begin
            found   = 1'b1;
            owner_d = cand;
          end
        end
        if (found) begin
          state_d = BUSY;
        end
      end
      BUSY: begin
        // A beat only ends the burst when it is both accepted and last.
        if (iresp.ready && iresp.last) begin
          state_d      = IDLE;
          last_grant_d = owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Live pass-through of the owner so per-beat write data reaches memory.
  always_comb begin
    oreq = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      oresps[i] = '0;
      if (state_q == BUSY && owner_q == IW'(i)) begin
        oreq      = ireqs[i];
        oresps[i] = iresp;
      end
    end
  end

endmodule

// File: tb/tb_cbus_arbiter.sv
// tb/tb_cbus_arbiter.sv - self-checking bench for cbus_arbiter
module tb_cbus_arbiter;
  import cbus_pkg::*;

  localparam int N = 3;

  logic       clk = 1'b0;
  logic       reset;
  cbus_req_t  ireqs  [N];
  cbus_resp_t oresps [N];
  cbus_req_t  oreq;
  cbus_resp_t iresp;

  int total = 0;
  int bad   = 0;

  cbus_arbiter #(.NUM_INPUTS(N)) dut (
    .clk   (clk),
    .reset (reset),
    .ireqs (ireqs),
    .oresps(oresps),
    .oreq  (oreq),
    .iresp (iresp)
  );

  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < N; i++) ireqs[i] = '0;
    iresp = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  function automatic cbus_req_t mk_req(logic w, logic [63:0] a, logic [7:0] l);
    cbus_req_t r;
    r          = '0;
    r.valid    = 1'b1;
    r.is_write = w;
    r.size     = 3'd3;
    r.addr     = a;
    r.len      = l;
    r.burst    = 2'b01;
    r.data     = {$urandom, $urandom};
    r.strobe   = w ? 8'hFF : 8'h00;
    return r;
  endfunction

  function automatic cbus_req_t rand_req();
    cbus_req_t r;
    r          = '0;
    r.valid    = 1'b1;
    r.is_write = 1'($urandom);
    r.size     = 3'($urandom);
    r.addr     = {$urandom, $urandom};
    r.len      = 8'($urandom_range(0, 5));
    r.burst    = 2'($urandom);
    r.data     = {$urandom, $urandom};
    r.strobe   = 8'($urandom);
    return r;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < N; i++) ireqs[i] = rand_req();
    iresp = {1'b1, 1'b1, $urandom, $urandom};
    #3;
    total++;
    if (oreq !== '0) begin bad++; $display("FAIL reset_oreq got=%h want=0", oreq); end
    next_cycle();
    for (int i = 0; i < N; i++) begin
      total++;
      if (oresps[i] !== '0) begin bad++; $display("FAIL reset_oresps[%0d] got=%h want=0", i, oresps[i]); end
    end
    clear_inputs();
    reset = 1'b0;
    #3;
    total++;
    if (oreq !== '0) begin bad++; $display("FAIL reset_release_idle got=%h want=0", oreq); end
  endtask

  task automatic test_single_read();
    cbus_req_t r;
    do_reset();
    r = mk_req(1'b0, 64'h8000_0000, MLEN16);
    ireqs[1] = r;
    #3;
    total++;
    if (oreq !== '0) begin bad++; $display("FAIL single_pre_grant got=%h want=0", oreq); end
    next_cycle();
    for (int w = 0; w < 2; w++) begin
      iresp = '0;
      #3;
      total++;
      if (oreq.addr !== 64'h8000_0000 || oreq !== r) begin
        bad++; $display("FAIL single_grant got=%h want=%h", oreq, r);
      end
      next_cycle();
    end
    for (int b = 0; b < 16; b++) begin
      iresp.ready = 1'b1;
      iresp.last  = (b == 15);
      iresp.data  = {$urandom, $urandom};
      #3;
      total++;
      if (oreq !== r) begin bad++; $display("FAIL single_beat%0d_oreq got=%h want=%h", b, oreq, r); end
      total++;
      if (oresps[1] !== iresp) begin bad++; $display("FAIL single_beat%0d_resp1 got=%h want=%h", b, oresps[1], iresp); end
      total++;
      if (oresps[0] !== '0) begin bad++; $display("FAIL single_beat%0d_resp0 got=%h want=0", b, oresps[0]); end
      next_cycle();
    end
    ireqs[1] = '0;
    iresp.ready = 1'b1;
    iresp.last  = 1'b0;
    #3;
    total++;
    if (oreq !== '0 || oresps[1] !== '0) begin
      bad++; $display("FAIL single_back_to_idle oreq=%h resp1=%h want=0", oreq, oresps[1]);
    end
  endtask

  task automatic test_both_valid();
    cbus_req_t r0, r1;
    do_reset();
    r0 = mk_req(1'b0, 64'h0000_1000, MLEN4);
    r1 = mk_req(1'b0, 64'h0000_2000, MLEN1);
    ireqs[0] = r0;
    ireqs[1] = r1;
    next_cycle();
    for (int b = 0; b < 4; b++) begin
      iresp.ready = 1'b1;
      iresp.last  = (b == 3);
      #3;
      total++;
      if (oreq !== r0 || oresps[1] !== '0) begin
        bad++; $display("FAIL both_first_owner beat%0d oreq=%h want=%h resp1=%h", b, oreq, r0, oresps[1]);
      end
      next_cycle();
    end
    ireqs[0] = '0;
    iresp = '0;
    #3;
    total++;
    if (oreq !== '0) begin bad++; $display("FAIL both_bubble got=%h want=0", oreq); end
    next_cycle();
    iresp.ready = 1'b1;
    iresp.last  = 1'b1;
    #3;
    total++;
    if (oreq.addr !== 64'h0000_2000 || oreq !== r1) begin
      bad++; $display("FAIL both_second_owner got=%h want=%h", oreq, r1);
    end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_rr_rerequest();
    cbus_req_t r0, r0b, r1, r2;
    do_reset();
    r0  = mk_req(1'b0, 64'h0000_0100, MLEN1);
    r0b = mk_req(1'b0, 64'h0000_0180, MLEN1);
    r1  = mk_req(1'b0, 64'h0000_0200, MLEN1);
    r2  = mk_req(1'b1, 64'h0000_0300, MLEN1);
    ireqs[0] = r0;
    ireqs[1] = r1;
    next_cycle();
    iresp = {1'b1, 1'b1, 64'h0};
    #3;
    total++;
    if (oreq !== r0) begin bad++; $display("FAIL rr_first got=%h want=%h", oreq, r0); end
    next_cycle();
    iresp = '0;
    ireqs[0] = r0b;
    #3;
    total++;
    if (oreq !== '0) begin bad++; $display("FAIL rr_bubble1 got=%h want=0", oreq); end
    next_cycle();
    iresp = {1'b1, 1'b1, 64'h0};
    #3;
    total++;
    if (oreq !== r1) begin bad++; $display("FAIL rr_input1_wins got=%h want=%h", oreq, r1); end
    next_cycle();
    iresp = '0;
    ireqs[1] = '0;
    ireqs[2] = r2;
    #3;
    next_cycle();
    iresp = {1'b1, 1'b1, 64'h0};
    #3;
    total++;
    if (oreq !== r2) begin bad++; $display("FAIL rr_input2_wins got=%h want=%h", oreq, r2); end
    next_cycle();
    iresp = '0;
    ireqs[2] = '0;
    #3;
    next_cycle();
    iresp = {1'b1, 1'b1, 64'h0};
    #3;
    total++;
    if (oreq !== r0b) begin bad++; $display("FAIL rr_wrap_to_0 got=%h want=%h", oreq, r0b); end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_write_burst();
    cbus_req_t   r;
    logic [63:0] wd;
    logic [7:0]  st;
    do_reset();
    r = mk_req(1'b1, 64'h8000_1000, MLEN4);
    ireqs[1] = r;
    next_cycle();
    for (int b = 0; b < 4; b++) begin
      wd = 64'h1111_1111_1111_1111 * 64'(b + 1);
      st = 8'hF0 ^ 8'(b);
      ireqs[1].data   = wd;
      ireqs[1].strobe = st;
      iresp.ready = 1'b1;
      iresp.last  = (b == 3);
      #3;
      total++;
      if (oreq.data !== wd || oreq.strobe !== st || oreq.addr !== 64'h8000_1000 || oreq.is_write !== 1'b1) begin
        bad++; $display("FAIL write_beat%0d data=%h strobe=%h want data=%h strobe=%h", b, oreq.data, oreq.strobe, wd, st);
      end
      next_cycle();
    end
    ireqs[1] = '0;
    iresp = '0;
    #3;
    total++;
    if (oreq !== '0) begin bad++; $display("FAIL write_end_idle got=%h want=0", oreq); end
  endtask

  task automatic test_last_without_ready();
    cbus_req_t  r;
    logic [1:0] pat [4];
    pat = '{2'b01, 2'b10, 2'b00, 2'b11};
    do_reset();
    r = mk_req(1'b0, 64'h0000_2000, MLEN1);
    ireqs[0] = r;
    next_cycle();
    for (int s = 0; s < 4; s++) begin
      iresp.ready = pat[s][1];
      iresp.last  = pat[s][0];
      #3;
      total++;
      if (oreq !== r) begin bad++; $display("FAIL lastready_step%0d got=%h want=%h", s, oreq, r); end
      next_cycle();
    end
    ireqs[0] = '0;
    iresp = '0;
    #3;
    total++;
    if (oreq !== '0) begin bad++; $display("FAIL lastready_end got=%h want=0", oreq); end
  endtask

  task automatic test_reset_mid_busy();
    cbus_req_t r0, r1;
    do_reset();
    r1 = mk_req(1'b0, 64'h8000_0000, MLEN16);
    r0 = mk_req(1'b0, 64'h0000_4000, MLEN1);
    ireqs[1] = r1;
    next_cycle();
    for (int b = 0; b < 4; b++) begin
      iresp = {1'b1, 1'b0, $urandom, $urandom};
      next_cycle();
    end
    iresp = {1'b1, 1'b0, $urandom, $urandom};
    ireqs[0] = r0;
    #2;
    total++;
    if (oreq !== r1) begin bad++; $display("FAIL midrst_before got=%h want=%h", oreq, r1); end
    reset = 1'b1;
    #1;
    total++;
    if (oreq.valid !== 1'b0 || oreq !== '0) begin bad++; $display("FAIL midrst_oreq got=%h want=0", oreq); end
    for (int i = 0; i < N; i++) begin
      total++;
      if (oresps[i] !== '0) begin bad++; $display("FAIL midrst_oresps[%0d] got=%h want=0", i, oresps[i]); end
    end
    next_cycle();
    reset = 1'b0;
    #3;
    next_cycle();
    #3;
    total++;
    if (oreq !== r0) begin bad++; $display("FAIL midrst_restart_input0 got=%h want=%h", oreq, r0); end
    clear_inputs();
  endtask

  // Transaction-level reference: pending requests, a round-robin pick
  // starting after the previous owner, and burst end on ready && last.
  task automatic test_random();
    bit         m_busy;
    int         m_owner, m_last, beats, pick, c;
    bit         done_q [N];
    cbus_resp_t exp_r;
    do_reset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_last  = N - 1;
    beats   = 0;
    for (int i = 0; i < N; i++) done_q[i] = 1'b0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (done_q[i]) begin
          done_q[i] = 1'b0;
          if ($urandom_range(0, 1) == 1) ireqs[i] = rand_req();
          else ireqs[i] = '0;
        end else if (!(m_busy && m_owner == i) && !ireqs[i].valid && $urandom_range(0, 2) == 0) begin
          ireqs[i] = rand_req();
        end
      end
      if (m_busy) begin
        ireqs[m_owner].valid  = ($urandom_range(0, 7) != 0);
        ireqs[m_owner].data   = {$urandom, $urandom};
        ireqs[m_owner].strobe = 8'($urandom);
        iresp.ready = 1'($urandom);
        iresp.last  = iresp.ready ? (beats == int'(ireqs[m_owner].len)) : ($urandom_range(0, 3) == 0);
        iresp.data  = {$urandom, $urandom};
      end else begin
        iresp = {1'($urandom), 1'($urandom), $urandom, $urandom};
      end
      #3;
      if (!m_busy) begin
        total++;
        if (oreq !== '0) begin bad++; $display("FAIL rand_idle_oreq cyc=%0d got=%h want=0", cyc, oreq); end
      end else begin
        total++;
        if (oreq !== ireqs[m_owner]) begin
          bad++; $display("FAIL rand_busy_oreq cyc=%0d owner=%0d got=%h want=%h", cyc, m_owner, oreq, ireqs[m_owner]);
        end
      end
      for (int i = 0; i < N; i++) begin
        exp_r = (m_busy && m_owner == i) ? iresp : '0;
        total++;
        if (oresps[i] !== exp_r) begin
          bad++; $display("FAIL rand_oresps[%0d] cyc=%0d got=%h want=%h", i, cyc, oresps[i], exp_r);
        end
      end
      if (!m_busy) begin
        pick = -1;
        for (int k = 1; k <= N; k++) begin
          c = (m_last + k) % N;
          if (pick < 0 && ireqs[c].valid) pick = c;
        end
        if (pick >= 0) begin
          m_busy  = 1'b1;
          m_owner = pick;
          beats   = 0;
        end
      end else if (iresp.ready) begin
        if (iresp.last) begin
          m_busy          = 1'b0;
          m_last          = m_owner;
          done_q[m_owner] = 1'b1;
        end else begin
          beats++;
        end
      end
      next_cycle();
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_read();
    test_both_valid();
    test_rr_rerequest();
    test_write_burst();
    test_last_without_ready();
    test_reset_mid_busy();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cbus_arbiter.md
# cbus_arbiter

Round-robin arbiter that shares the single `cbus_req_t`/`cbus_resp_t` memory bus between several cache masters, typically the instruction cache (port 0) and the data cache (port 1). A requester is granted the bus for one complete burst transaction, from the cycle the bus is granted to the beat with `ready && last`. The block sits between the caches and the AXI bridge. Only the granted requester's traffic is visible downstream.

## Interface
Parameters:
- `NUM_INPUTS`, default 2: number of requesters, range 2..8.

Ports:
- `clk` in 1: single clock; all state is updated on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `ireqs` in `NUM_INPUTS` x `cbus_req_t` (151 b each): requests from the masters.
- `oresps` out `NUM_INPUTS` x `cbus_resp_t` (66 b each): responses to the masters.
- `oreq` out `cbus_req_t`: request to the memory side.
- `iresp` in `cbus_resp_t`: response from the memory side.

## Operation
- State machine has two states, IDLE and BUSY. It holds two registers:
  - `owner`, width clog2(`NUM_INPUTS`).
  - `last_grant`, the same width.
- Reset (asynchronous, takes effect immediately):
  - state = IDLE, `owner` = 0, `last_grant` = `NUM_INPUTS-1`, so input 0 has first priority after reset.
  - `oreq` = all zero and every `oresps[i]` = all zero while reset is high.
- IDLE:
  - `oreq` = '0 and every `oresps[i]` = '0.
  - If any `ireqs[i].valid` is set, select the first valid index searching from `last_grant+1` upward, wrapping modulo `NUM_INPUTS`.
  - On the next edge: `owner` = selected index and state = BUSY.
  - If no input is valid, stay in IDLE.
- BUSY:
  - `oreq` = `ireqs[owner]`, passed through live so per-beat write `data`/`strobe` updates reach memory.
  - `oresps[owner]` = `iresp`; all other `oresps[i]` = '0.
  - On an edge with `iresp.ready && iresp.last`: state = IDLE and `last_grant` = `owner`.
  - Otherwise remain in BUSY; a non-last `ready` beat does not end the transaction.
- Requesters must hold `valid` and the address fields stable until their last beat. If the owner drops `valid` in BUSY, `oreq.valid` follows it low, but the arbiter keeps the grant until `ready && last`.
- Non-owners that are valid during BUSY are not lost: they remain pending and are evaluated at the next IDLE.
- Ending a transaction requires both `ready` and `last`. A `last` without `ready` is ignored.
- The combinational paths are `ireqs` -> `oreq` and `iresp` -> `oresps`. There is no path `iresp` -> `oreq`.

## Timing
- Grant latency:
  - A request that arrives while the arbiter is in IDLE at edge N appears on `oreq` in the cycle after edge N.
  - Zero extra cycles if the request was already valid in the IDLE cycle.
- There is exactly one IDLE bubble cycle between back-to-back transactions, including when the same requester asks again.
- Fairness:
  - With all `NUM_INPUTS` continuously valid, grants rotate 0,1,...,N-1,0,...
  - Any pending requester waits at most `NUM_INPUTS-1` transactions.
- Single-beat transactions (`len` = MLEN1, `ready && last` in the first BUSY cycle) occupy one BUSY cycle plus one IDLE cycle.
- Reset asserted mid-BUSY:
  - Aborts immediately: `oreq.valid` goes low asynchronously and the state becomes IDLE.
  - After release, priority restarts at input 0.

## Test plan
- Reset, then only `ireqs[1].valid` (read, addr `0x8000_0000`, len MLEN16):
  - `oreq` shows input 1 one cycle later.
  - After 16 `ready` beats with `last` on the 16th, the arbiter returns to IDLE.
  - `oresps[0]` stays 0 throughout.
- Both inputs valid after reset:
  - Input 0 is granted first.
  - After its `ready && last`, one IDLE cycle follows, then input 1 is granted with its address.
- Input 0 re-requests immediately after completing while input 1 is also pending: input 1 wins the next grant (round-robin).
- Write burst on input 1 with `data` changing every beat (`0x11..`, `0x22..`, ...): `oreq.data` tracks `ireqs[1].data` in the same cycle, and `strobe` is passed through unchanged.
- `iresp.last` pulsed without `ready`, then `ready` without `last`: the arbiter stays in BUSY. Only a cycle with `ready=1, last=1` ends the transaction.
- Reset asserted in the 5th beat of a 16-beat read: `oreq.valid` = 0 in the same cycle and all `oresps` = 0. After release with both inputs valid, input 0 is granted.
